// File: rtl/y86_pkg.sv
// Shared Y86 constants and types for the execute stage: instruction codes,
// ALU and condition function encodings, status codes and the condition-code record.
package y86_pkg;

  localparam logic [3:0] HALT  = 4'h0;
  localparam logic [3:0] NOP   = 4'h1;
  localparam logic [3:0] RRMOV = 4'h2;
  localparam logic [3:0] IRMOV = 4'h3;
  localparam logic [3:0] RMMOV = 4'h4;
  localparam logic [3:0] MRMOV = 4'h5;
  localparam logic [3:0] OPQ   = 4'h6;
  localparam logic [3:0] JXX   = 4'h7;
  localparam logic [3:0] CALL  = 4'h8;
  localparam logic [3:0] RET   = 4'h9;
  localparam logic [3:0] PUSH  = 4'hA;
  localparam logic [3:0] POP   = 4'hB;

  localparam int unsigned AOK = 1;
  localparam int unsigned HLT = 2;
  localparam int unsigned ADR = 3;
  localparam int unsigned INS = 4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_XOR = 4'd3
  } alu_fn_t;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'd0,
    C_LE     = 4'd1,
    C_L      = 4'd2,
    C_E      = 4'd3,
    C_NE     = 4'd4,
    C_GE     = 4'd5,
    C_G      = 4'd6
  } cond_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  // Condition test against previously committed flags; unknown codes are never taken.
  function automatic logic cond_eval(input logic [3:0] ifun, input cc_t f);
    logic lt;
    lt = f.sf ^ f.of;
    case (ifun)
      C_ALWAYS: return 1'b1;
      C_LE:     return lt | f.zf;
      C_L:      return lt;
      C_E:      return f.zf;
      C_NE:     return ~f.zf;
      C_GE:     return ~lt;
      C_G:      return ~lt & ~f.zf;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational WIDTH-bit Y86 ALU: add, subtract (b - a), and, xor, with Z/S/O flags.
module y86_alu
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_fn_t          fn,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int MSB = WIDTH - 1;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fn)
      ALU_ADD: begin
        result = a + b;
        of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (b[MSB] != a[MSB]) && (result[MSB] != b[MSB]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: ;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[MSB];

endmodule

// File: rtl/y86_execute_stage.sv
// Y86 execute stage: ALU operand selection, condition codes, jXX/cmovXX condition
// and the E/M pipeline register with stall/bubble control.
module y86_execute_stage
  import y86_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAT_W-1:0] E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [WIDTH-1:0]  E_valA,
  input  logic [WIDTH-1:0]  E_valB,
  input  logic [WIDTH-1:0]  E_valC,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [WIDTH-1:0]  e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_cnd,
  output logic [2:0]        cc,
  output logic [STAT_W-1:0] M_stat,
  output logic [3:0]        M_icode,
  output logic [3:0]        M_ifun,
  output logic              M_cnd,
  output logic [WIDTH-1:0]  M_valE,
  output logic [WIDTH-1:0]  M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);

  localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(AOK);
  localparam logic [WIDTH-1:0]  PLUS8    = WIDTH'(8);
  localparam logic [WIDTH-1:0]  MINUS8   = ~WIDTH'(7);

  typedef struct packed {
    logic [STAT_W-1:0] stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic              cnd;
    logic [WIDTH-1:0]  vale;
    logic [WIDTH-1:0]  vala;
    logic [3:0]        dste;
    logic [3:0]        dstm;
  } em_t;

  localparam em_t EM_BUBBLE = '{stat: STAT_AOK, icode: NOP, ifun: 4'h0, cnd: 1'b0,
                                vale: '0, vala: '0, dste: RNONE, dstm: RNONE};
  localparam cc_t CC_RESET  = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  alu_fn_t          alu_fn;
  logic             alu_en;
  logic             alu_zf, alu_sf, alu_of;
  logic             set_cc;
  cc_t              cc_q;
  em_t              em_q, em_d;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = ALU_ADD;
    alu_en = 1'b1;
    case (E_icode)
      OPQ: begin
        alu_a  = E_valA;
        alu_b  = E_valB;
        alu_fn = alu_fn_t'(E_ifun);
      end
      RRMOV:        alu_a = E_valA;
      IRMOV:        alu_a = E_valC;
      RMMOV, MRMOV: begin alu_a = E_valC; alu_b = E_valB; end
      CALL, PUSH:   begin alu_a = MINUS8; alu_b = E_valB; end
      RET, POP:     begin alu_a = PLUS8;  alu_b = E_valB; end
      default:      alu_en = 1'b0;
    endcase
  end

  y86_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fn     (alu_fn),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  assign e_valE = alu_en ? alu_result : '0;
  assign set_cc = (E_icode == OPQ) && (E_ifun <= 4'd3) &&
                  (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  // Conditions use committed flags, so an OPq directly ahead has already written cc.
  assign e_cnd  = ((E_icode == RRMOV) || (E_icode == JXX)) && cond_eval(E_ifun, cc_q);
  assign e_dstE = ((E_icode == RRMOV) && !e_cnd) ? RNONE : E_dstE;

  assign em_d = '{stat: E_stat, icode: E_icode, ifun: E_ifun, cnd: e_cnd,
                  vale: e_valE, vala: E_valA, dste: e_dstE, dstm: E_dstM};

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_q <= CC_RESET;
      em_q <= EM_BUBBLE;
    end else begin
      if (set_cc) cc_q <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
      if (M_bubble)     em_q <= EM_BUBBLE;
      else if (!M_stall) em_q <= em_d;
    end
  end

  assign cc      = cc_q;
  assign M_stat  = em_q.stat;
  assign M_icode = em_q.icode;
  assign M_ifun  = em_q.ifun;
  assign M_cnd   = em_q.cnd;
  assign M_valE  = em_q.vale;
  assign M_valA  = em_q.vala;
  assign M_dstE  = em_q.dste;
  assign M_dstM  = em_q.dstm;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed scoreboard bench for y86_execute_stage (64-bit instance plus a 32-bit
// instance for address-arithmetic wrap).
module tb_y86_execute_stage;

  localparam logic [3:0] T_NOP = 4'h1, T_RRMOV = 4'h2, T_IRMOV = 4'h3, T_RMMOV = 4'h4,
                         T_MRMOV = 4'h5, T_OPQ = 4'h6, T_PUSH = 4'hA, T_POP = 4'hB;
  localparam logic [2:0] S_AOK = 3'd1, S_ADR = 3'd3;
  localparam logic [3:0] R_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } em_t;

  localparam em_t BUBBLE = '{stat: S_AOK, icode: T_NOP, ifun: 4'h0, cnd: 1'b0,
                             vale: 64'h0, vala: 64'h0, dste: R_NONE, dstm: R_NONE};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        M_stall, M_bubble;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_ifun, M_dstE, M_dstM;
  logic        e_cnd, M_cnd;
  logic [2:0]  cc, M_stat;

  logic [3:0]  n_icode;
  logic [31:0] n_valB;
  logic [31:0] n_valE, n_MvalE, n_MvalA;
  logic [3:0]  n_dstE, n_Micode, n_Mifun, n_MdstE, n_MdstM;
  logic        n_cnd, n_Mcnd;
  logic [2:0]  n_cc, n_Mstat;

  int  tests = 0;
  int  fails = 0;
  em_t sb_q[$];
  em_t cur;
  em_t last_m;

  always #5 clk = ~clk;

  y86_execute_stage #(.WIDTH(64), .STAT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_ifun(M_ifun), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  y86_execute_stage #(.WIDTH(32), .STAT_W(3)) dut32 (
    .clk(clk), .rst_n(rst_n), .E_stat(S_AOK), .E_icode(n_icode), .E_ifun(4'h0),
    .E_valA(32'h0), .E_valB(n_valB), .E_valC(32'h0), .E_dstE(4'h4), .E_dstM(R_NONE),
    .m_stat(S_AOK), .W_stat(S_AOK), .M_stall(1'b0), .M_bubble(1'b0),
    .e_valE(n_valE), .e_dstE(n_dstE), .e_cnd(n_cnd), .cc(n_cc),
    .M_stat(n_Mstat), .M_icode(n_Micode), .M_ifun(n_Mifun), .M_cnd(n_Mcnd),
    .M_valE(n_MvalE), .M_valA(n_MvalA), .M_dstE(n_MdstE), .M_dstM(n_MdstM)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction in E and check the same-cycle outputs.
  task automatic issue(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] dste, input logic [3:0] dstm,
                       input logic [63:0] exp_vale, input logic [3:0] exp_dste,
                       input logic exp_cnd, input string tag);
    E_stat = S_AOK; E_icode = icode; E_ifun = ifun;
    E_valA = va; E_valB = vb; E_valC = vc; E_dstE = dste; E_dstM = dstm;
    cur = '{stat: S_AOK, icode: icode, ifun: ifun, cnd: exp_cnd, vale: exp_vale,
            vala: va, dste: exp_dste, dstm: dstm};
    #1;
    check({tag, ".e_valE"}, e_valE, exp_vale);
    check({tag, ".e_dstE"}, {60'h0, e_dstE}, {60'h0, exp_dste});
    check({tag, ".e_cnd"}, {63'h0, e_cnd}, {63'h0, exp_cnd});
  endtask

  // One clock edge: queue the expected E/M contents, then compare after the edge.
  task automatic tick(input logic [2:0] exp_cc, input string tag);
    em_t exp;
    em_t got;
    if (!rst_n || M_bubble) exp = BUBBLE;
    else if (M_stall)       exp = last_m;
    else                    exp = cur;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    got = '{stat: M_stat, icode: M_icode, ifun: M_ifun, cnd: M_cnd, vale: M_valE,
            vala: M_valA, dste: M_dstE, dstm: M_dstM};
    check({tag, ".M_icode"}, {60'h0, got.icode}, {60'h0, exp.icode});
    check({tag, ".M_valE"}, got.vale, exp.vale);
    check({tag, ".M_dstE"}, {60'h0, got.dste}, {60'h0, exp.dste});
    check({tag, ".M_other"}, {got.stat, got.ifun, got.cnd, got.dstm, got.vala[31:0]},
          {exp.stat, exp.ifun, exp.cnd, exp.dstm, exp.vala[31:0]});
    check({tag, ".cc"}, {61'h0, cc}, {61'h0, exp_cc});
    last_m = exp;
  endtask

  initial begin
    rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
    m_stat = S_AOK; W_stat = S_AOK;
    n_icode = T_NOP; n_valB = 32'h0;
    issue(T_NOP, 4'h0, 64'h0, 64'h0, 64'h0, R_NONE, R_NONE, 64'h0, R_NONE, 1'b0, "nop");
    tick(3'b100, "reset");
    rst_n = 1'b1;
    tick(3'b100, "idle");

    issue(T_OPQ, 4'h1, 64'h1, 64'h0, 64'h0, 4'h2, R_NONE,
          64'hFFFF_FFFF_FFFF_FFFF, 4'h2, 1'b0, "sub");
    tick(3'b010, "sub");
    issue(T_OPQ, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h2, R_NONE,
          64'hFFFF_FFFF_FFFF_FFFE, 4'h2, 1'b0, "add_ovf");
    tick(3'b011, "add_ovf");
    issue(T_RRMOV, 4'h2, 64'h55, 64'h0, 64'h0, 4'h3, R_NONE, 64'h55, R_NONE, 1'b0, "cmovl_f");
    tick(3'b011, "cmovl_f");
    issue(T_OPQ, 4'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'h2, R_NONE,
          64'h0, 4'h2, 1'b0, "add_zero");
    tick(3'b100, "add_zero");
    issue(T_RRMOV, 4'h1, 64'h66, 64'h0, 64'h0, 4'h3, R_NONE, 64'h66, 4'h3, 1'b1, "cmovle_t");
    tick(3'b100, "cmovle_t");
    issue(T_RRMOV, 4'h3, 64'h67, 64'h0, 64'h0, 4'h3, R_NONE, 64'h67, 4'h3, 1'b1, "cmove_t");
    tick(3'b100, "cmove_t");
    issue(T_RRMOV, 4'h2, 64'h68, 64'h0, 64'h0, 4'h3, R_NONE, 64'h68, R_NONE, 1'b0, "cmovl_z");
    tick(3'b100, "cmovl_z");
    issue(T_OPQ, 4'h5, 64'h3, 64'h4, 64'h0, 4'h7, R_NONE, 64'h0, 4'h7, 1'b0, "op_bad");
    tick(3'b100, "op_bad");

    m_stat = S_ADR;
    issue(T_OPQ, 4'h0, 64'h2, 64'h3, 64'h0, 4'h2, R_NONE, 64'h5, 4'h2, 1'b0, "add_madr");
    tick(3'b100, "add_madr");
    m_stat = S_AOK;

    n_icode = T_PUSH; n_valB = 32'h0;
    issue(T_PUSH, 4'h0, 64'h9, 64'h100, 64'h0, 4'h4, R_NONE, 64'hF8, 4'h4, 1'b0, "push");
    check("push32.e_valE", {32'h0, n_valE}, 64'hFFFF_FFF8);
    tick(3'b100, "push");
    n_icode = T_POP;
    issue(T_POP, 4'h0, 64'h100, 64'h100, 64'h0, 4'h4, 4'h6, 64'h108, 4'h4, 1'b0, "pop");
    check("pop32.e_valE", {32'h0, n_valE}, 64'h8);
    n_icode = T_PUSH; n_valB = 32'h100;
    #1 check("push32_b.e_valE", {32'h0, n_valE}, 64'hF8);
    tick(3'b100, "pop");

    issue(T_IRMOV, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h5, R_NONE, 64'h1234, 4'h5, 1'b0, "irmov");
    tick(3'b100, "irmov");
    M_stall = 1'b1;
    issue(T_MRMOV, 4'h0, 64'h0, 64'h20, 64'h10, R_NONE, 4'h6, 64'h30, R_NONE, 1'b0, "stall1");
    tick(3'b100, "stall1");
    issue(T_RMMOV, 4'h0, 64'hAB, 64'h40, 64'h8, R_NONE, R_NONE, 64'h48, R_NONE, 1'b0, "stall2");
    tick(3'b100, "stall2");
    issue(T_OPQ, 4'h1, 64'h1, 64'h0, 64'h0, 4'h2, R_NONE,
          64'hFFFF_FFFF_FFFF_FFFF, 4'h2, 1'b0, "stall3");
    tick(3'b010, "stall3");
    M_bubble = 1'b1;
    tick(3'b010, "stall_bubble");
    M_stall = 1'b0; M_bubble = 1'b0;

    issue(T_IRMOV, 4'h0, 64'h0, 64'h0, 64'h77, 4'h1, R_NONE, 64'h77, 4'h1, 1'b0, "irmov2");
    tick(3'b010, "irmov2");
    issue(T_OPQ, 4'h0, 64'h1, 64'h1, 64'h0, 4'h2, R_NONE, 64'h2, 4'h2, 1'b0, "add_pos");
    tick(3'b000, "add_pos");
    M_stall = 1'b1; rst_n = 1'b0;
    issue(T_OPQ, 4'h1, 64'h1, 64'h0, 64'h0, 4'h2, R_NONE,
          64'hFFFF_FFFF_FFFF_FFFF, 4'h2, 1'b0, "rst_stall");
    tick(3'b100, "rst_stall");
    rst_n = 1'b1; M_stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
